trap_sequencer: RTL and testbench

- Machine-mode trap/return controller between hazard unit and priv CSR block.
- Prioritises exceptions and interrupts, latches cause/epc/tval, drains the pipeline, commits trap-state CSR writes, then redirects fetch.
- Produces the priv-side hazard signals: pipe_clear, insert_pc, priv_pc, intr.

---
 rtl/trap_seq_pkg.sv | 29 ++
 rtl/trap_priority_enc.sv | 42 ++++
 rtl/trap_sequencer.sv | 164 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/trap_seq_pkg.sv
// Shared types and cause codes for the machine-mode trap sequencer.
package trap_seq_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} trap_state_t;
  typedef enum logic {TRAP, RET} trap_kind_t;

  localparam int TRAP_WORD_W = 32;
  localparam int INTR_BIT    = TRAP_WORD_W - 1;
  localparam int CODE_W      = 5;

  typedef logic [CODE_W-1:0] code_t;

  // Exception codes (mcause with interrupt bit clear)
  localparam code_t EX_INSN_MAL    = 5'd0;
  localparam code_t EX_INSN_FAULT  = 5'd1;
  localparam code_t EX_ILLEGAL     = 5'd2;
  localparam code_t EX_BREAKPOINT  = 5'd3;
  localparam code_t EX_LOAD_MAL    = 5'd4;
  localparam code_t EX_LOAD_FAULT  = 5'd5;
  localparam code_t EX_STORE_MAL   = 5'd6;
  localparam code_t EX_STORE_FAULT = 5'd7;
  localparam code_t EX_ECALL_M     = 5'd11;

  // Interrupt codes (mcause with interrupt bit set)
  localparam code_t INT_SOFT_M  = 5'd3;
  localparam code_t INT_TIMER_M = 5'd7;
  localparam code_t INT_EXT_M   = 5'd11;

endpackage

// File: rtl/trap_priority_enc.sv
// Combinational exception/interrupt prioritiser; exceptions always win over interrupts.
module trap_priority_enc
  import trap_seq_pkg::*;
(
  input  logic  fault_insn,
  input  logic  mal_insn,
  input  logic  illegal_insn,
  input  logic  breakpoint,
  input  logic  env,
  input  logic  mal_l,
  input  logic  mal_s,
  input  logic  fault_l,
  input  logic  fault_s,
  input  logic  ext_int,
  input  logic  soft_int,
  input  logic  timer_int,
  input  logic  mie_global,
  output logic  valid,
  output logic  is_intr,
  output code_t code
);

  always_comb begin
    valid   = 1'b1;
    is_intr = 1'b0;
    code    = '0;
    if (fault_insn)                   code = EX_INSN_FAULT;
    else if (mal_insn)                code = EX_INSN_MAL;
    else if (illegal_insn)            code = EX_ILLEGAL;
    else if (breakpoint)              code = EX_BREAKPOINT;
    else if (env)                     code = EX_ECALL_M;
    else if (mal_l)                   code = EX_LOAD_MAL;
    else if (mal_s)                   code = EX_STORE_MAL;
    else if (fault_l)                 code = EX_LOAD_FAULT;
    else if (fault_s)                 code = EX_STORE_FAULT;
    else if (mie_global && ext_int)   begin is_intr = 1'b1; code = INT_EXT_M;   end
    else if (mie_global && soft_int)  begin is_intr = 1'b1; code = INT_SOFT_M;  end
    else if (mie_global && timer_int) begin is_intr = 1'b1; code = INT_TIMER_M; end
    else                              valid = 1'b0;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer: detect, drain, commit CSR writes, redirect fetch.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets (mtvec mode 01).
module trap_sequencer
  import trap_seq_pkg::*;
#(
  parameter int WORD_W        = 32,
  parameter int DRAIN_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fault_insn,
  input  logic              mal_insn,
  input  logic              illegal_insn,
  input  logic              breakpoint,
  input  logic              env,
  input  logic              mal_l,
  input  logic              mal_s,
  input  logic              fault_l,
  input  logic              fault_s,
  input  logic              ret,
  input  logic              ext_int,
  input  logic              soft_int,
  input  logic              timer_int,
  input  logic              mie_global,
  input  logic [WORD_W-1:0] epc,
  input  logic [WORD_W-1:0] badaddr,
  input  logic [WORD_W-1:0] mtvec,
  input  logic [WORD_W-1:0] mepc,
  input  logic              pipe_drained,
  output logic              pipe_clear,
  output logic              trap_we,
  output logic              ret_we,
  output logic [WORD_W-1:0] cause,
  output logic [WORD_W-1:0] epc_out,
  output logic [WORD_W-1:0] tval,
  output logic              insert_pc,
  output logic [WORD_W-1:0] priv_pc,
  output logic              intr,
  output logic              busy,
  output logic              drain_err
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);

  trap_state_t       state;
  trap_kind_t        kind;
  logic              intr_lat;
  logic [WORD_W-1:0] ret_target;
  logic [CNT_W-1:0]  drain_cnt;

  logic              ev_valid;
  logic              ev_intr;
  code_t             ev_code;
  logic [WORD_W-1:0] base_pc;
  logic [WORD_W-1:0] trap_pc;
  logic              drain_done;

  trap_priority_enc u_prio (
    .fault_insn   (fault_insn),
    .mal_insn     (mal_insn),
    .illegal_insn (illegal_insn),
    .breakpoint   (breakpoint),
    .env          (env),
    .mal_l        (mal_l),
    .mal_s        (mal_s),
    .fault_l      (fault_l),
    .fault_s      (fault_s),
    .ext_int      (ext_int),
    .soft_int     (soft_int),
    .timer_int    (timer_int),
    .mie_global   (mie_global),
    .valid        (ev_valid),
    .is_intr      (ev_intr),
    .code         (ev_code)
  );

  assign base_pc = {mtvec[WORD_W-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign trap_pc = (intr_lat && (mtvec[1:0] == 2'b01))
                 ? base_pc + {cause[WORD_W-3:0], 2'b00}
                 : base_pc;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign trap_pc = base_pc;
`endif

  // The last allowed DRAIN cycle is the one where the counter is one short of the limit.
  assign drain_done = pipe_drained || (drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      kind       <= TRAP;
      intr_lat   <= 1'b0;
      ret_target <= '0;
      drain_cnt  <= '0;
      pipe_clear <= 1'b0;
      trap_we    <= 1'b0;
      ret_we     <= 1'b0;
      cause      <= '0;
      epc_out    <= '0;
      tval       <= '0;
      insert_pc  <= 1'b0;
      priv_pc    <= '0;
      intr       <= 1'b0;
      busy       <= 1'b0;
      drain_err  <= 1'b0;
    end else begin
      trap_we   <= 1'b0;
      ret_we    <= 1'b0;
      insert_pc <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_valid) begin
            kind       <= TRAP;
            intr_lat   <= ev_intr;
            cause      <= {ev_intr, {(WORD_W-1-CODE_W){1'b0}}, ev_code};
            epc_out    <= epc;
            tval       <= ev_intr ? '0 : badaddr;
            drain_cnt  <= '0;
            pipe_clear <= 1'b1;
            busy       <= 1'b1;
            state      <= DRAIN;
          end else if (ret) begin
            kind       <= RET;
            intr_lat   <= 1'b0;
            ret_target <= mepc;
            drain_cnt  <= '0;
            pipe_clear <= 1'b1;
            busy       <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_done) begin
            if (!pipe_drained) drain_err <= 1'b1;
            trap_we <= (kind == TRAP);
            ret_we  <= (kind == RET);
            intr    <= intr_lat;
            state   <= COMMIT;
          end
        end
        COMMIT: begin
          insert_pc <= 1'b1;
          priv_pc   <= (kind == RET) ? ret_target : trap_pc;
          state     <= REDIRECT;
        end
        REDIRECT: begin
          pipe_clear <= 1'b0;
          busy       <= 1'b0;
          intr       <= 1'b0;
          priv_pc    <= '0;
          drain_cnt  <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomised self-checking bench for trap_sequencer against a table-driven transaction model.
module tb_trap_sequencer;
  import trap_seq_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         fault_insn = 0, mal_insn = 0, illegal_insn = 0, breakpoint = 0, env = 0;
  logic         mal_l = 0, mal_s = 0, fault_l = 0, fault_s = 0;
  logic         ret = 0, ext_int = 0, soft_int = 0, timer_int = 0, mie_global = 0;
  logic [W-1:0] epc = 0, badaddr = 0, mtvec = 0, mepc = 0;
  logic         pipe_drained = 0;
  logic         pipe_clear, trap_we, ret_we, insert_pc, intr, busy, drain_err;
  logic [W-1:0] cause, epc_out, tval, priv_pc;

  int checks   = 0;
  int failures = 0;

  // Priority order tables: index 0 is highest priority.
  int ex_codes[9]  = '{1, 0, 2, 3, 11, 4, 6, 5, 7};
  int int_codes[3] = '{11, 3, 7};

  logic [W-1:0] exp_cause = 0, exp_epc = 0, exp_tval = 0;
  logic         exp_err = 0;

  trap_sequencer #(.WORD_W(W), .DRAIN_TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env(env), .mal_l(mal_l), .mal_s(mal_s),
    .fault_l(fault_l), .fault_s(fault_s), .ret(ret),
    .ext_int(ext_int), .soft_int(soft_int), .timer_int(timer_int),
    .mie_global(mie_global), .epc(epc), .badaddr(badaddr), .mtvec(mtvec),
    .mepc(mepc), .pipe_drained(pipe_drained), .pipe_clear(pipe_clear),
    .trap_we(trap_we), .ret_we(ret_we), .cause(cause), .epc_out(epc_out),
    .tval(tval), .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr),
    .busy(busy), .drain_err(drain_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_flags(input logic [8:0] exf, input logic [2:0] inf, input logic r);
    fault_insn = exf[0]; mal_insn = exf[1]; illegal_insn = exf[2]; breakpoint = exf[3];
    env = exf[4]; mal_l = exf[5]; mal_s = exf[6]; fault_l = exf[7]; fault_s = exf[8];
    ext_int = inf[0]; soft_int = inf[1]; timer_int = inf[2];
    ret = r;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pipe_clear"}, pipe_clear, 0);
    check_eq({tag, "_trap_we"},    trap_we, 0);
    check_eq({tag, "_ret_we"},     ret_we, 0);
    check_eq({tag, "_cause"},      cause, 0);
    check_eq({tag, "_epc_out"},    epc_out, 0);
    check_eq({tag, "_tval"},       tval, 0);
    check_eq({tag, "_insert_pc"},  insert_pc, 0);
    check_eq({tag, "_priv_pc"},    priv_pc, 0);
    check_eq({tag, "_intr"},       intr, 0);
    check_eq({tag, "_busy"},       busy, 0);
    check_eq({tag, "_drain_err"},  drain_err, 0);
  endtask

  // One whole transaction, entered and left in IDLE just after a clock edge.
  // dly: first DRAIN cycle index at which pipe_drained is presented.
  task automatic run_txn(input logic [8:0] exf, input logic [2:0] inf, input logic mie,
                         input logic r, input logic [W-1:0] e, input logic [W-1:0] b,
                         input logic [W-1:0] mt, input logic [W-1:0] me, input int dly);
    logic ev, is_i, is_ret;
    int code, len;
    logic [W-1:0] exp_pc;
    ev = 0; is_i = 0; code = 0;
    for (int i = 0; i < 9; i++)
      if (exf[i] && !ev) begin ev = 1; code = ex_codes[i]; end
    if (!ev && mie)
      for (int i = 0; i < 3; i++)
        if (inf[i] && !ev) begin ev = 1; is_i = 1; code = int_codes[i]; end
    is_ret = !ev && r;

    drive_flags(exf, inf, r);
    mie_global = mie; epc = e; badaddr = b; mtvec = mt; mepc = me; pipe_drained = 0;
    step();
    // Perturb sampled inputs so latching is actually exercised.
    drive_flags(9'd0, 3'd0, 1'b0);
    epc = $urandom; badaddr = $urandom; mepc = $urandom;

    if (!ev && !is_ret) begin
      check_eq("noev_busy", busy, 0);
      check_eq("noev_pipe_clear", pipe_clear, 0);
      return;
    end
    if (ev) begin
      exp_cause = (is_i ? 32'h8000_0000 : 32'h0) | W'(code);
      exp_epc   = e;
      exp_tval  = is_i ? '0 : b;
    end
    len = ((dly < 14) ? dly : 14) + 1;

    for (int k = 0; k < len; k++) begin
      check_eq("drain_busy", busy, 1);
      check_eq("drain_pipe_clear", pipe_clear, 1);
      check_eq("drain_trap_we", trap_we, 0);
      check_eq("drain_ret_we", ret_we, 0);
      check_eq("drain_insert_pc", insert_pc, 0);
      pipe_drained = (k >= dly);
      step();
    end
    pipe_drained = 0;
    if (dly >= 15) exp_err = 1;

    check_eq("commit_trap_we", trap_we, ev);
    check_eq("commit_ret_we", ret_we, is_ret);
    check_eq("commit_intr", intr, is_i);
    check_eq("commit_cause", cause, exp_cause);
    check_eq("commit_epc_out", epc_out, exp_epc);
    check_eq("commit_tval", tval, exp_tval);
    check_eq("commit_pipe_clear", pipe_clear, 1);
    check_eq("commit_insert_pc", insert_pc, 0);
    check_eq("commit_drain_err", drain_err, exp_err);

    exp_pc = is_ret ? me : (mt & ~32'h3);
`ifdef TRAP_VECTORED_EN
    if (is_i && mt[1:0] == 2'b01) exp_pc = exp_pc + 4 * code;
`endif
    step();
    check_eq("redir_insert_pc", insert_pc, 1);
    check_eq("redir_priv_pc", priv_pc, exp_pc);
    check_eq("redir_intr", intr, is_i);
    check_eq("redir_trap_we", trap_we, 0);
    check_eq("redir_ret_we", ret_we, 0);
    check_eq("redir_pipe_clear", pipe_clear, 1);
    step();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_pipe_clear", pipe_clear, 0);
    check_eq("idle_insert_pc", insert_pc, 0);
    check_eq("idle_intr", intr, 0);
    check_eq("idle_drain_err", drain_err, exp_err);
  endtask

  initial begin
    logic [8:0] exf;
    logic [2:0] inf;
    int mode;

    RST = 1;
    repeat (2) step();
    check_all_zero("reset");
    RST = 0;

    run_txn(9'b000000100, 3'b000, 0, 0, 32'h100, 32'h13, 32'h2000, 32'h0, 0);
    run_txn(9'b100100000, 3'b000, 0, 0, 32'h204, 32'hDEAD_BEE0, 32'h2000, 32'h0, 2);
    run_txn(9'b000010000, 3'b100, 1, 0, 32'h308, 32'h55, 32'h2000, 32'h0, 1);
    run_txn(9'b000000000, 3'b110, 1, 0, 32'h40C, 32'h77, 32'h2001, 32'h0, 0);
    run_txn(9'b000000000, 3'b000, 1, 1, 32'h510, 32'h0, 32'h2000, 32'h400, 0);
    run_txn(9'b000000000, 3'b001, 1, 1, 32'h614, 32'h99, 32'h2000, 32'h400, 0);
    run_txn(9'b000000000, 3'b111, 0, 0, 32'h700, 32'h1, 32'h2000, 32'h0, 0);
    run_txn(9'b000000000, 3'b010, 0, 1, 32'h700, 32'h1, 32'h2000, 32'h800, 3);
    run_txn(9'b000000000, 3'b001, 1, 0, 32'h900, 32'h1, 32'h2001, 32'h0, 14);
    run_txn(9'b000000100, 3'b000, 0, 0, 32'hA00, 32'hBAD, 32'h3000, 32'h0, 40);

    for (int n = 0; n < 80; n++) begin
      mode = $urandom_range(0, 3);
      exf = 9'd0; inf = 3'd0;
      if (mode == 0 || mode == 3) exf = 9'($urandom) & 9'($urandom) & 9'($urandom);
      if (mode != 2 || $urandom_range(0, 1) == 1) inf = 3'($urandom);
      run_txn(exf, inf, 1'($urandom), 1'($urandom),
              $urandom, $urandom, $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4));
    end

    // Reset while a commit strobe is showing.
    drive_flags(9'b000000100, 3'b000, 1'b0);
    mtvec = 32'h2000; pipe_drained = 1;
    step();
    drive_flags(9'd0, 3'd0, 1'b0);
    step();
    check_eq("rstc_trap_we", trap_we, 1);
    RST = 1;
    step();
    RST = 0;
    pipe_drained = 0;
    check_all_zero("rstc");
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rstc_insert_pc", insert_pc, 0);
      check_eq("rstc_busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
